// File: rtl/adc16dv160_input_read.sv
// AXI4-Lite read channel for the adc16dv160_input register block: config readback, sticky status, ID.
// Optional: ADC16DV160_INPUT_RD_SLVERR_EN makes unmapped reads return SLVERR instead of OKAY.
module adc16dv160_input_read #(
   parameter logic [31:0] ID_VALUE = 32'hAD16_0001
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic [31:0] ARADDR,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RVALID,
   input  logic        RREADY,
   input  logic [31:0] dsize,
   input  logic        cr_test,
   input  logic        cr_rt,
   input  logic        cr_ls,
   input  logic [15:0] ls_thr,
   input  logic [31:0] ls_n,
   input  logic        st_busy,
   input  logic        st_done_set,
   input  logic        st_ovf_set,
   output logic [1:0]  o_dbg_state
);

   localparam logic [7:0] AXI_ADDR_CR     = 8'h00;
   localparam logic [7:0] AXI_ADDR_DSIZE  = 8'h04;
   localparam logic [7:0] AXI_ADDR_LS_THR = 8'h08;
   localparam logic [7:0] AXI_ADDR_LS_N   = 8'h0C;
   localparam logic [7:0] AXI_ADDR_SR     = 8'h10;
   localparam logic [7:0] AXI_ADDR_ID     = 8'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } state_t;

   // Handshake: AR completes on the S1 cycle (ARREADY high while ARVALID is held);
   // R completes on the first S2 cycle with RREADY high. RDATA/RRESP are frozen in S2.
   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;
   logic        r_done;
   logic        r_ovf;
   logic [31:0] w_rdata;
   logic [1:0]  w_rresp;
   logic        w_sr_clr;
   logic        w_unused;

   assign w_unused = ^ARADDR[31:8];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= S0;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S0:      if (ARVALID) w_next_state = S1;
         S1:      w_next_state = S2;
         S2:      if (RREADY) w_next_state = S0;
         default: w_next_state = S0;
      endcase
   end

   always_comb begin
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      case (r_state)
         S1:      ARREADY = 1'b1;
         S2:      RVALID  = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_rdata = 32'h0;
      w_rresp = RESP_OKAY;
      case (ARADDR[7:0])
         AXI_ADDR_CR:     w_rdata = {28'h0, cr_ls, cr_rt, cr_test, 1'b0};
         AXI_ADDR_DSIZE:  w_rdata = dsize;
         AXI_ADDR_LS_THR: w_rdata = {16'h0, ls_thr};
         AXI_ADDR_LS_N:   w_rdata = ls_n;
         AXI_ADDR_SR:     w_rdata = {29'h0, r_ovf, r_done, st_busy};
         AXI_ADDR_ID:     w_rdata = ID_VALUE;
         default: begin
`ifdef ADC16DV160_INPUT_RD_SLVERR_EN
            w_rresp = RESP_SLVERR;
`else
            w_rresp = RESP_OKAY;
`endif
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rdata <= 32'h0;
         r_rresp <= RESP_OKAY;
      end else if (r_state == S1) begin
         r_rdata <= w_rdata;
         r_rresp <= w_rresp;
      end
   end

   // A set pulse coinciding with the clear wins, so the event is seen by the next SR read.
   assign w_sr_clr = (r_state == S1) && (ARADDR[7:0] == AXI_ADDR_SR);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_done <= st_done_set | (r_done & ~w_sr_clr);
         r_ovf  <= st_ovf_set  | (r_ovf  & ~w_sr_clr);
      end
   end

   assign RDATA       = r_rdata;
   assign RRESP       = r_rresp;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adc16dv160_input_read.sv
// Directed bench for adc16dv160_input_read: driver tasks push expected {RRESP,RDATA}, a monitor pops on R handshake.
module tb_adc16dv160_input_read;

   logic        ACLK;
   logic        ARESETN;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;
   logic [31:0] dsize;
   logic        cr_test, cr_rt, cr_ls;
   logic [15:0] ls_thr;
   logic [31:0] ls_n;
   logic        st_busy, st_done_set, st_ovf_set;
   logic [1:0]  dbg_state;

   logic [33:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

`ifdef ADC16DV160_INPUT_RD_SLVERR_EN
   localparam logic [1:0] UNMAPPED_RESP = 2'b10;
`else
   localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

   adc16dv160_input_read dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .dsize(dsize), .cr_test(cr_test), .cr_rt(cr_rt), .cr_ls(cr_ls),
      .ls_thr(ls_thr), .ls_n(ls_n),
      .st_busy(st_busy), .st_done_set(st_done_set), .st_ovf_set(st_ovf_set),
      .o_dbg_state(dbg_state)
   );

   // clock / reset
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge ACLK) begin
      if (ARESETN && RVALID && RREADY) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rdata got=%h exp=none", {RRESP, RDATA});
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({RRESP, RDATA} !== e) begin
               errors++;
               $display("FAIL rresp_rdata got=%h exp=%h", {RRESP, RDATA}, e);
            end
         end
      end
   end

   // driver: one read, checking ARREADY at n+1 and RVALID at n+2
   task automatic do_read(input logic [7:0] addr, input logic [33:0] exp, input logic done_pulse);
      @(posedge ACLK); #1;
      ARADDR  = {24'h0, addr};
      ARVALID = 1'b1;
      RREADY  = 1'b1;
      exp_q.push_back(exp);
      @(posedge ACLK); #1;
      st_done_set = done_pulse;
      @(negedge ACLK);
      chk("arready_n1", {32'h0, ARREADY, RVALID}, 34'b10);
      @(posedge ACLK); #1;
      ARVALID     = 1'b0;
      st_done_set = 1'b0;
      @(negedge ACLK);
      chk("rvalid_n2", {32'h0, ARREADY, RVALID}, 34'b01);
      @(posedge ACLK);
   endtask

   task automatic pulse_ovf();
      @(posedge ACLK); #1;
      st_ovf_set = 1'b1;
      @(posedge ACLK); #1;
      st_ovf_set = 1'b0;
   endtask

   initial begin
      ARESETN = 1'b1; ARADDR = 32'h0; ARVALID = 1'b0; RREADY = 1'b1;
      dsize = 32'h0; cr_test = 1'b0; cr_rt = 1'b0; cr_ls = 1'b0;
      ls_thr = 16'h0; ls_n = 32'h0;
      st_busy = 1'b0; st_done_set = 1'b0; st_ovf_set = 1'b0;
      #2 ARESETN = 1'b0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      chk("reset_rdata_rresp", {RRESP, RDATA}, 34'h0);
      chk("reset_handshake", {30'h0, ARREADY, RVALID, dbg_state}, 34'h0);
      @(posedge ACLK); #1 ARESETN = 1'b1;

      // basic register readback
      dsize = 32'h0001_0000;
      do_read(8'h04, {2'b00, 32'h0001_0000}, 1'b0);
      cr_test = 1'b1; cr_ls = 1'b1;
      do_read(8'h00, {2'b00, 32'h0000_000A}, 1'b0);
      do_read(8'h14, {2'b00, 32'hAD16_0001}, 1'b0);
      ls_thr = 16'h1234;
      do_read(8'h08, {2'b00, 32'h0000_1234}, 1'b0);

      // sticky overflow, clear on SR read, live busy
      st_busy = 1'b1;
      pulse_ovf();
      do_read(8'h10, {2'b00, 32'h0000_0005}, 1'b0);
      st_busy = 1'b0;
      do_read(8'h10, {2'b00, 32'h0000_0000}, 1'b0);

      // non-SR read leaves flags alone
      pulse_ovf();
      do_read(8'h04, {2'b00, 32'h0001_0000}, 1'b0);
      do_read(8'h10, {2'b00, 32'h0000_0004}, 1'b0);

      // done set on the clearing cycle survives to the next SR read
      do_read(8'h10, {2'b00, 32'h0000_0000}, 1'b1);
      do_read(8'h10, {2'b00, 32'h0000_0002}, 1'b0);
      do_read(8'h10, {2'b00, 32'h0000_0000}, 1'b0);

      // back-pressure in S2 with changing source and a pending ARVALID
      ls_n = 32'hCAFE_0001;
      @(posedge ACLK); #1;
      ARADDR = 32'h0C; ARVALID = 1'b1; RREADY = 1'b0;
      exp_q.push_back({2'b00, 32'hCAFE_0001});
      @(posedge ACLK);
      @(posedge ACLK); #1;
      ARADDR = 32'h04;
      for (int i = 0; i < 10; i++) begin
         ls_n = ls_n + 32'h1;
         @(negedge ACLK);
         chk("hold_rvalid_arready", {32'h0, RVALID, ARREADY}, 34'b10);
         chk("hold_rdata", {RRESP, RDATA}, {2'b00, 32'hCAFE_0001});
         @(posedge ACLK); #1;
      end
      RREADY = 1'b1;
      exp_q.push_back({2'b00, 32'h0001_0000});
      @(posedge ACLK);
      @(negedge ACLK);
      chk("no_accept_in_s0", {33'h0, ARREADY}, 34'b0);
      @(posedge ACLK);
      @(negedge ACLK);
      chk("accept_after_s0", {33'h0, ARREADY}, 34'b1);
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      @(posedge ACLK);
      @(posedge ACLK);

      // unmapped address
      do_read(8'hFC, {UNMAPPED_RESP, 32'h0}, 1'b0);

      // reset while in S2 abandons the read
      pulse_ovf();
      @(posedge ACLK); #1;
      ARADDR = 32'h14; ARVALID = 1'b1; RREADY = 1'b0;
      @(posedge ACLK);
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      @(negedge ACLK);
      chk("pre_reset_rvalid", {33'h0, RVALID}, 34'b1);
      #2 ARESETN = 1'b0;
      #1;
      chk("async_reset_outputs", {30'h0, RVALID, ARREADY, dbg_state}, 34'h0);
      chk("async_reset_rdata", {RRESP, RDATA}, 34'h0);
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      RREADY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         chk("no_rvalid_after_reset", {33'h0, RVALID}, 34'b0);
      end
      st_busy = 1'b1;
      do_read(8'h10, {2'b00, 32'h0000_0001}, 1'b0);
      st_busy = 1'b0;

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge ACLK);
      chk("queue_drained", 34'(exp_q.size()), 34'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
